// File: rtl/dram_lane_packer_pkg.sv
// Shared defaults, derived widths and lane-select helper for the DRAM lane packer.
package dram_lane_packer_pkg;

  localparam int LANE_W_DEF      = 16;
  localparam int LANES_IN_DEF    = 4;
  localparam int FRAME_LANES_DEF = 17;
  localparam int CNT_W_DEF       = 16;

  // Worst case fill: one lane short of a frame plus a full-width beat.
  function automatic int acc_lanes(input int frame_lanes, input int lanes_in);
    return frame_lanes + lanes_in - 1;
  endfunction

  function automatic int cnt_width(input int frame_lanes, input int lanes_in);
    return $clog2(acc_lanes(frame_lanes, lanes_in) + 1);
  endfunction

  function automatic int nl_width(input int lanes_in);
    return $clog2(lanes_in + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int lane_offset(input int lanes_in, input int nl, input logic inv);
    return inv ? lanes_in - nl : 0;
  endfunction

endpackage

// File: rtl/dram_lane_select.sv
// Extracts nlanes lanes from the input bus, right-justified to lane 0.
module dram_lane_select
  import dram_lane_packer_pkg::*;
#(
  parameter int LANE_W   = LANE_W_DEF,
  parameter int LANES_IN = LANES_IN_DEF
) (
  input  logic [LANE_W*LANES_IN-1:0]       din,
  input  logic [nl_width(LANES_IN)-1:0]    nlanes,
  input  logic                             inv,
  output logic [LANES_IN-1:0][LANE_W-1:0]  lanes
);

  localparam int SW = idx_width(LANES_IN);

  logic [LANES_IN-1:0][LANE_W-1:0] src;
  int off;

  assign src = din;

  always_comb begin
    off   = lane_offset(LANES_IN, int'(nlanes), inv);
    lanes = '0;
    for (int i = 0; i < LANES_IN; i++) begin
      if (i < int'(nlanes) && off + i >= 0 && off + i < LANES_IN)
        lanes[i] = src[SW'(off + i)];
    end
  end

endmodule

// File: rtl/dram_lane_packer.sv
// Packs variable-length lane groups into fixed-size DRAM frames with residue
// carry, flush/zero-pad, valid/ready on both sides and a sticky length error.
module dram_lane_packer
  import dram_lane_packer_pkg::*;
#(
  parameter int LANE_W      = LANE_W_DEF,
  parameter int LANES_IN    = LANES_IN_DEF,
  parameter int FRAME_LANES = FRAME_LANES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [LANE_W*LANES_IN-1:0]        din,
  input  logic [nl_width(LANES_IN)-1:0]     nlanes,
  input  logic                              inv,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              flush,
  output logic [LANE_W*FRAME_LANES-1:0]     dout,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic [CNT_W-1:0]                  frame_cnt,
  output logic                              err_len
);

  localparam int ACC = acc_lanes(FRAME_LANES, LANES_IN);
  localparam int CW  = cnt_width(FRAME_LANES, LANES_IN);
  localparam int SW  = idx_width(LANES_IN);

  logic [ACC-1:0][LANE_W-1:0]         acc, acc_n;
  logic [FRAME_LANES-1:0][LANE_W-1:0] obuf, obuf_n;
  logic [LANES_IN-1:0][LANE_W-1:0]    sel;
  logic [CW-1:0]                      cnt, cnt_n;
  logic [SW-1:0]                      si;
  logic                               flush_pend;
  logic                               legal, take, accept, xfer, flush_set;
  int                                 cnt_i, nl_i;

  dram_lane_select #(
    .LANE_W   (LANE_W),
    .LANES_IN (LANES_IN)
  ) u_sel (
    .din    (din),
    .nlanes (nlanes),
    .inv    (inv),
    .lanes  (sel)
  );

  always_comb begin
    cnt_i = int'(cnt);
    nl_i  = int'(nlanes);
  end

  // Accept and transfer are mutually exclusive: in_ready needs cnt below a
  // frame with no flush pending, transfer needs the opposite.
  assign in_ready  = (cnt_i < FRAME_LANES) && !flush_pend;
  assign legal     = (nl_i >= 1) && (nl_i <= LANES_IN);
  assign take      = in_valid && in_ready;
  assign accept    = take && legal;
  assign xfer      = ((cnt_i >= FRAME_LANES) || flush_pend) && (!out_valid || out_ready);
  assign flush_set = flush && ((cnt_i != 0) || accept);
  assign dout      = obuf;

  always_comb begin
    acc_n  = acc;
    obuf_n = obuf;
    cnt_n  = cnt;
    si     = '0;
    if (xfer) begin
      for (int k = 0; k < FRAME_LANES; k++)
        obuf_n[k] = (k < cnt_i) ? acc[k] : '0;
      for (int k = 0; k < ACC - FRAME_LANES; k++)
        acc_n[k] = acc[k + FRAME_LANES];
      for (int k = ACC - FRAME_LANES; k < ACC; k++)
        acc_n[k] = '0;
      cnt_n = (cnt_i > FRAME_LANES) ? CW'(cnt_i - FRAME_LANES) : '0;
    end else if (accept) begin
      for (int k = 0; k < ACC; k++) begin
        if (k >= cnt_i && k < cnt_i + nl_i) begin
          si       = SW'(k - cnt_i);
          acc_n[k] = sel[si];
        end
      end
      cnt_n = CW'(cnt_i + nl_i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc        <= '0;
      obuf       <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_cnt  <= '0;
      err_len    <= 1'b0;
    end else begin
      acc  <= acc_n;
      obuf <= obuf_n;
      cnt  <= cnt_n;
      if (xfer) begin
        out_valid  <= 1'b1;
        out_last   <= flush_pend;
        frame_cnt  <= frame_cnt + CNT_W'(1);
        // A flush landing on a transfer only sticks if residue remains.
        flush_pend <= flush && (cnt_i > FRAME_LANES);
      end else begin
        if (out_valid && out_ready)
          out_valid <= 1'b0;
        if (flush_set)
          flush_pend <= 1'b1;
      end
      if (take && !legal)
        err_len <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dram_lane_packer.sv
// Directed and randomized checks of dram_lane_packer against a lane-queue model.
module tb_dram_lane_packer;

  localparam int LW = 16;
  localparam int LI = 4;
  localparam int FL = 17;
  localparam int CW = 16;
  localparam int FW = LW * FL;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [LW*LI-1:0] din = '0;
  logic [2:0]    nlanes = '0;
  logic          inv = 1'b0;
  logic          in_valid = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b1;
  logic          in_ready, out_valid, out_last, err_len;
  logic [FW-1:0] dout;
  logic [CW-1:0] frame_cnt;

  dram_lane_packer dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .nlanes    (nlanes),
    .inv       (inv),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .dout      (dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .frame_cnt (frame_cnt),
    .err_len   (err_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] data;
    logic          last;
  } frame_t;

  frame_t        exp_q[$];
  logic [LW-1:0] lq[$];
  int            model_frames = 0;
  logic          model_err = 1'b0;
  logic          hold = 1'b0;
  logic [FW-1:0] hold_dout;
  logic          hold_last;
  int            checks = 0;
  int            failures = 0;
  int            stalls = 0;
  int            mon_n, mon_off;
  frame_t        mon_f;

  task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Close a frame from the head of the lane stream, zero-padding the tail.
  function automatic void emit(input logic last);
    frame_t f;
    f.data = '0;
    f.last = last;
    for (int k = 0; k < FL; k++)
      if (lq.size() > 0) f.data[k*LW +: LW] = lq.pop_front();
    exp_q.push_back(f);
    model_frames++;
  endfunction

  // Flush is only driven while in_ready is high, so the model sees it as
  // "close whatever lanes exist after this cycle's beat".
  always @(negedge clk) begin
    if (!rst) begin
      lq.delete();
      exp_q.delete();
      model_frames = 0;
      model_err    = 1'b0;
      hold         = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_dout", dout, hold_dout);
        chk("hold_last", out_last, hold_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_frame", 1, 0);
        else begin
          mon_f = exp_q.pop_front();
          chk("frame_dout", dout, mon_f.data);
          chk("frame_last", out_last, mon_f.last);
        end
      end
      hold      = out_valid && !out_ready;
      hold_dout = dout;
      hold_last = out_last;
      if (in_valid && in_ready) begin
        mon_n = int'(nlanes);
        if (mon_n >= 1 && mon_n <= LI) begin
          mon_off = inv ? LI - mon_n : 0;
          for (int i = 0; i < mon_n; i++) lq.push_back(din[(mon_off+i)*LW +: LW]);
        end else model_err = 1'b1;
      end
      if (flush && in_ready && lq.size() > 0) emit(1'b1);
      else while (lq.size() >= FL) emit(1'b0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!in_ready && w < 50) begin
      step();
      w++;
      stalls++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic send_beat(input logic [LW*LI-1:0] d, input int n, input logic iv, input logic fl);
    wait_ready();
    din      = d;
    nlanes   = 3'(n);
    inv      = iv;
    in_valid = 1'b1;
    flush    = fl;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic do_flush();
    wait_ready();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) step();
    chk("drain_left", exp_q.size(), 0);
    step();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    step();
    step();
    rst = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_err_len", err_len, 0);

    // 17 single lanes -> one frame, valid one edge after the completing accept
    for (int k = 0; k < 17; k++) send_beat(64'(k + 1), 1, 1'b0, 1'b0);
    chk("t1_lat_n", out_valid, 0);
    step();
    chk("t1_lat_n1", out_valid, 1);
    chk("t1_lane0", dout[15:0], 16'h0001);
    chk("t1_lane16", dout[271:256], 16'h0011);
    chk("t1_frame_cnt", frame_cnt, 1);
    chk("t1_last", out_last, 0);
    drain();

    // Full-width beats: residue carries, one input bubble per frame
    stalls = 0;
    for (int b = 0; b < 9; b++)
      send_beat({16'(4*b+3), 16'(4*b+2), 16'(4*b+1), 16'(4*b)}, 4, 1'b0, 1'b0);
    chk("t2_stalls", stalls, 1);
    do_flush();
    drain();
    chk("t2_frame_cnt", frame_cnt, 4);

    // inv=1 picks the top lanes; flush with the beat zero-pads the frame
    send_beat(64'hAAAA_BBBB_CCCC_DDDD, 3, 1'b1, 1'b1);
    for (int i = 0; i < 20 && !out_valid; i++) step();
    chk("t3_valid", out_valid, 1);
    chk("t3_dout", dout, {224'h0, 48'hAAAA_BBBB_CCCC});
    chk("t3_last", out_last, 1);
    drain();

    // Backpressure through two completed frames
    out_ready = 1'b0;
    for (int b = 0; b < 9; b++)
      send_beat({16'(256+4*b+3), 16'(256+4*b+2), 16'(256+4*b+1), 16'(256+4*b)}, 4, 1'b0, 1'b0);
    repeat (4) step();
    chk("t4_in_ready", in_ready, 0);
    chk("t4_valid", out_valid, 1);
    chk("t4_held_lane0", dout[15:0], 16'h0100);
    chk("t4_frame_cnt", frame_cnt, 6);
    drain();
    chk("t4_frame_cnt_drained", frame_cnt, 7);
    do_flush();
    drain();

    // Illegal lengths are swallowed and set the sticky flag
    send_beat(64'hDEAD_BEEF_1234_5678, 0, 1'b0, 1'b0);
    chk("t5_err", err_len, 1);
    send_beat(64'hDEAD_BEEF_1234_5678, 5, 1'b0, 1'b0);
    for (int k = 0; k < 17; k++) send_beat(64'(512 + k), 1, 1'b0, 1'b0);
    drain();
    chk("t5_err_sticky", err_len, 1);
    chk("t5_frame_cnt", frame_cnt, 9);

    // Reset with a held frame and 9 lanes in the accumulator
    out_ready = 1'b0;
    for (int k = 0; k < 26; k++) send_beat(64'(1024 + k), 1, 1'b0, 1'b0);
    chk("t6_pre_valid", out_valid, 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_frame_cnt", frame_cnt, 0);
    chk("t6_err_len", err_len, 0);
    chk("t6_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 17; k++) send_beat(64'(768 + k), 1, 1'b0, 1'b0);
    drain();
    chk("t6_frame_cnt_after", frame_cnt, 1);

    // Randomized traffic with random backpressure, flushes and bad lengths
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      din       = {$urandom, $urandom};
      r         = int'($urandom_range(0, 19));
      nlanes    = (r < 18) ? 3'(1 + r % 4) : ((r == 18) ? 3'd0 : 3'd6);
      inv       = 1'($urandom_range(0, 1));
      flush     = in_ready && ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    drain();
    do_flush();
    drain();
    chk("rnd_frame_cnt", frame_cnt, 16'(model_frames));
    chk("rnd_err_len", err_len, model_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
